// File: rtl/fetch_stage_if.sv
// Bundle between the fetch stage, the instruction memory and the IF/ID register.
// The master side drives control and memory data; the slave side is fetch_stage.
interface fetch_stage_if #(
    parameter int PC_WIDTH = 15
);
    logic                stall;
    logic                flush;
    logic                redirect_valid;
    logic [PC_WIDTH-1:0] redirect_pc;
    logic [PC_WIDTH-1:0] pc;
    logic [31:0]         insData;
    logic [31:0]         if_id_ins;
    logic [PC_WIDTH-1:0] if_id_pc_plus4;
    logic                if_id_valid;
    logic                halted;
    logic [31:0]         fetch_count;

    modport master (
        output stall, flush, redirect_valid, redirect_pc, insData,
        input  pc, if_id_ins, if_id_pc_plus4, if_id_valid,
        input  halted, fetch_count
    );

    modport slave (
        input  stall, flush, redirect_valid, redirect_pc, insData,
        output pc, if_id_ins, if_id_pc_plus4, if_id_valid,
        output halted, fetch_count
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives imem, fills the IF/ID register.
// Handles stall, flush, branch redirect and halt on the end-of-program word.
module fetch_stage #(
    parameter int                  PC_WIDTH  = 15,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
    parameter logic [31:0]         HALT_WORD = 32'hFFFF_FFFF
) (
    input logic          clk,
    input logic          rst_n,
    fetch_stage_if.slave bus
);
    typedef enum logic {RUN, HALT} state_e;

    localparam logic [PC_WIDTH-1:0] FOUR  = PC_WIDTH'(4);
    localparam logic [PC_WIDTH-1:0] ALIGN = ~PC_WIDTH'(3);

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]         ins_q, ins_d;
    logic [PC_WIDTH-1:0] pp4_q, pp4_d;
    logic                valid_q, valid_d;
    logic [31:0]         cnt_q, cnt_d;
    logic [PC_WIDTH-1:0] pc_inc;

    assign pc_inc = pc_q + FOUR;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ins_d   = ins_q;
        pp4_d   = pp4_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (bus.redirect_valid) begin
            pc_d    = bus.redirect_pc & ALIGN;
            state_d = RUN;
            ins_d   = '0;
            pp4_d   = '0;
            valid_d = 1'b0;
        end else if (state_q == HALT) begin
            ins_d   = '0;
            pp4_d   = '0;
            valid_d = 1'b0;
        end else if (bus.flush) begin
            if (!bus.stall) pc_d = pc_inc;
            ins_d   = '0;
            pp4_d   = '0;
            valid_d = 1'b0;
        end else if (bus.stall) begin
            state_d = state_q;
        end else if (bus.insData == HALT_WORD) begin
            // Halt word is swallowed: PC stays on it, IF/ID gets a bubble.
            state_d = HALT;
            ins_d   = '0;
            pp4_d   = '0;
            valid_d = 1'b0;
        end else begin
            pc_d    = pc_inc;
            ins_d   = bus.insData;
            pp4_d   = pc_inc;
            valid_d = 1'b1;
            cnt_d   = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            ins_q   <= '0;
            pp4_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ins_q   <= ins_d;
            pp4_q   <= pp4_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.pc             = pc_q;
    assign bus.if_id_ins      = ins_q;
    assign bus.if_id_pc_plus4 = pp4_q;
    assign bus.if_id_valid    = valid_q;
    assign bus.halted         = (state_q == HALT);
    assign bus.fetch_count    = cnt_q;
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the MIPS pipeline: owns the program counter, drives the byte address into the instruction memory, and captures the returned 32-bit word into the IF/ID pipeline register for decode. Supports pipeline stall, IF/ID flush, branch/jump redirect, and a halt state entered on the end-of-program marker word. Sits directly upstream of the instruction memory and directly upstream of the decode stage.

## Interface
- PC_WIDTH, 15, byte-address width of the instruction memory
- RESET_PC, 0, PC value loaded at reset; must be a multiple of 4
- HALT_WORD, 32'hFFFF_FFFF, fetched word that stops fetch

- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  hazard unit: hold PC and IF/ID contents
- flush  in  1  squash the IF/ID register (insert bubble)
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_pc  in  PC_WIDTH  branch/jump target byte address
- pc  out  PC_WIDTH  byte address to instruction memory (registered)
- insData  in  32  instruction word from memory at `pc` (combinational, same cycle)
- if_id_ins  out  32  captured instruction
- if_id_pc_plus4  out  PC_WIDTH  address of the captured instruction + 4
- if_id_valid  out  1  IF/ID holds a real instruction
- halted  out  1  fetch is in HALT state
- fetch_count  out  32  count of instructions delivered to IF/ID

## Operation
- States: RUN, HALT. Reset -> RUN.
- Priority each cycle: redirect_valid > flush > halt-detect > stall > normal advance.
- redirect_valid (either state): pc <= {redirect_pc[PC_WIDTH-1:2], 2'b00}; IF/ID bubble; state <= RUN. Overrides stall.
- flush without redirect: IF/ID bubble; pc advances by 4 unless stall, in which case pc holds.
- Halt detect (RUN, no redirect/flush, stall=0, insData == HALT_WORD): state <= HALT; pc holds; IF/ID bubble; halt word never captured.
- stall (RUN, no redirect/flush): pc, IF/ID, fetch_count all hold.
- Normal advance (RUN): pc <= pc + 4; if_id_ins <= insData; if_id_pc_plus4 <= pc + 4; if_id_valid <= 1; fetch_count += 1.
- HALT without redirect: pc holds; IF/ID bubble; fetch_count holds; stall/flush ignored.
- Bubble = if_id_ins 0 (sll $0,$0,0 NOP), if_id_pc_plus4 0, if_id_valid 0.
- Arithmetic: pc + 4 is modulo 2^PC_WIDTH (0x7FFC -> 0x0000). fetch_count wraps modulo 2^32. redirect_pc[1:0] ignored.
- halted = (state == HALT).

## Timing
- rst_n low (async, any time, including mid-stall or in HALT): pc = RESET_PC, if_id_ins = 0, if_id_pc_plus4 = 0, if_id_valid = 0, halted = 0, fetch_count = 0, state RUN. Outputs hold these values while rst_n is low.
- First rising edge after rst_n release captures the word at RESET_PC.
- Latency: word presented for `pc` in cycle N appears on if_id_* after edge ending cycle N (1 cycle).
- Redirect in cycle N: pc = target in cycle N+1; first valid target instruction in IF/ID at N+2.
- Halt: halt word at pc in cycle N -> halted = 1 from N+1; pc frozen at halt address.
- No handshake with memory; insData is sampled every non-stall edge.

## Test plan
- Reset then free-run, mem words 0x20080001, 0x20090002, 0x01095020 at 0,4,8 -> pc 0,4,8,12; if_id_ins follows 1 cycle later, if_id_pc_plus4 4,8,12; fetch_count 1,2,3.
- stall high 2 cycles at pc=8 -> pc stays 8, IF/ID holds word from 4, fetch_count unchanged; resumes at 12 on release.
- redirect_valid with redirect_pc=0x0043 while stall=1 -> next pc 0x0040, if_id_valid 0, next cycle captures word at 0x40.
- HALT_WORD at 0x10 -> halted 1, pc stays 0x10, if_id_valid 0 indefinitely; redirect to 0x00 -> halted 0, fetch restarts at 0.
- Run to pc=0x7FFC -> next pc 0x0000, if_id_pc_plus4 0x0000 for that word.
- Assert rst_n low mid-stall with if_id_valid=1 -> all outputs immediately take reset values without a clock edge.
